// File: rtl/papu_codec_serdes.sv
// Codec-side serializer/deserializer for the PAPU audio path: generates BCLK/LRCK,
// shifts each mixer word onto both DAC slots and captures the left ADC slot.
module papu_codec_serdes #(
    parameter int BCLK_DIV = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] audio_output,
    output logic        sample_req,
    output logic [15:0] audio_input,
    output logic        sample_end,
    output logic        aud_bclk,
    output logic        aud_daclrck,
    output logic        aud_dacdat,
    output logic        aud_adclrck,
    input  logic        aud_adcdat
);
    // A width of at least one bit keeps BCLK_DIV=1 legal (counter pinned at 0).
    localparam int            DW      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [4:0]    bit_cnt;
    logic [4:0]    bit_nxt;
    logic [15:0]   tx_word;
    logic [15:0]   rx_shift;
    logic          tick;
    logic          rise;
    logic          fall;

    assign tick        = (div_cnt == DIV_MAX);
    assign rise        = tick & ~aud_bclk;
    assign fall        = tick & aud_bclk;
    assign bit_nxt     = bit_cnt + 5'd1;
    assign aud_adclrck = aud_daclrck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            aud_bclk <= 1'b0;
        end else if (tick) begin
            div_cnt  <= '0;
            aud_bclk <= ~aud_bclk;
        end else begin
            div_cnt  <= div_cnt + DW'(1);
        end
    end

    // DAC side: everything moves on the BCLK falling edge so data is stable at the rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
            tx_word     <= '0;
            sample_req  <= 1'b0;
            sample_end  <= 1'b0;
            audio_input <= '0;
        end else begin
            sample_req <= fall & (bit_nxt == 5'd31);
            sample_end <= fall & (bit_nxt == 5'd16);
            if (fall) begin
                bit_cnt     <= bit_nxt;
                aud_daclrck <= bit_nxt[4];
                if (bit_nxt == 5'd0) begin
                    tx_word    <= audio_output;
                    aud_dacdat <= audio_output[15];
                end else begin
                    aud_dacdat <= tx_word[4'd15 - bit_nxt[3:0]];
                end
                if (bit_nxt == 5'd16)
                    audio_input <= rx_shift;
            end
        end
    end

    // ADC side: sample on BCLK rise during the left slot only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rx_shift <= '0;
        else if (rise && !bit_cnt[4])
            rx_shift <= {rx_shift[14:0], aud_adcdat};
    end

endmodule

// File: tb/tb_papu_codec_serdes.sv
// Bench for papu_codec_serdes: three dividers (1, 2, 4) side by side against a
// timing-arithmetic model of BCLK/frame position, plus literal frame/latency checks.
module tb_papu_codec_serdes;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [15:0] ao [NI];
    logic [1:0] mode [NI];
    logic [NI-1:0] req, send, bclk, dlrck, dacdat, alrck, adcdat;
    logic [NI-1:0][15:0] ain;
    logic [15:0] lword = 16'h1234;
    logic [15:0] rword = 16'hFFFF;

    int nchk = 0;
    int nerr = 0;

    // model state: t = clk edges since reset release
    int t = 0;
    logic [15:0] m_word [NI];
    logic [15:0] m_shift [NI];
    logic [15:0] m_in [NI];
    logic [31:0] f_bits [NI];
    logic [31:0] frames [NI][8];
    int req_at [NI][2];
    int n_req [NI];

    always #5 clk = ~clk;

    function automatic int div_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : 4;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        int k = 0;
        logic rbit = 1'b0;
        logic cbit;

        // codec model: advances one bit per BCLK fall, left word then right word
        always @(negedge bclk[g] or negedge reset_n) begin
            if (!reset_n) k <= 0;
            else          k <= (k + 1) % 32;
            rbit <= 1'($urandom_range(0, 1));
        end
        assign cbit = k[4] ? rword[15 - k[3:0]] : lword[15 - k[3:0]];
        assign adcdat[g] = (mode[g] == 2'd1) ? dacdat[g] :
                           (mode[g] == 2'd2) ? rbit : cbit;

        papu_codec_serdes #(.BCLK_DIV(D)) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .audio_output (ao[g]),
            .sample_req   (req[g]),
            .audio_input  (ain[g]),
            .sample_end   (send[g]),
            .aud_bclk     (bclk[g]),
            .aud_daclrck  (dlrck[g]),
            .aud_dacdat   (dacdat[g]),
            .aud_adclrck  (alrck[g]),
            .aud_adcdat   (adcdat[g])
        );
    end

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d] t=%0d: got %h expected %h", name, g, t, act, exp);
        end
    endtask

    task automatic check_zero();
        for (int g = 0; g < NI; g++) begin
            chk("rst_bclk", g, 32'(bclk[g]), 32'd0);
            chk("rst_daclrck", g, 32'(dlrck[g]), 32'd0);
            chk("rst_adclrck", g, 32'(alrck[g]), 32'd0);
            chk("rst_dacdat", g, 32'(dacdat[g]), 32'd0);
            chk("rst_sample_req", g, 32'(req[g]), 32'd0);
            chk("rst_sample_end", g, 32'(send[g]), 32'd0);
            chk("rst_audio_input", g, 32'(ain[g]), 32'd0);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int g = 0; g < NI; g++) begin
            m_word[g]  = '0;
            m_shift[g] = '0;
            m_in[g]    = '0;
            f_bits[g]  = '0;
        end
    endtask

    // One clk edge: update the model from inputs seen at the edge, then compare 1 ns later.
    task automatic step();
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
            #1;
            check_zero();
        end else begin
            t++;
            for (int g = 0; g < NI; g++) begin
                int d, ph, bc;
                d  = div_of(g);
                ph = t % (2 * d);
                bc = (t / (2 * d)) % 32;
                if (ph == d) begin
                    if (bc < 16) m_shift[g] = {m_shift[g][14:0], adcdat[g]};
                    f_bits[g][31 - bc] = dacdat[g];
                    if (bc == 31 && t / (64 * d) < 8) frames[g][t / (64 * d)] = f_bits[g];
                end else if (ph == 0) begin
                    if (bc == 0)  m_word[g] = ao[g];
                    if (bc == 16) m_in[g]   = m_shift[g];
                end
            end
            #1;
            for (int g = 0; g < NI; g++) begin
                int d, ph, bc;
                d  = div_of(g);
                ph = t % (2 * d);
                bc = (t / (2 * d)) % 32;
                chk("bclk", g, 32'(bclk[g]), 32'((t / d) % 2));
                chk("daclrck", g, 32'(dlrck[g]), 32'(bc / 16));
                chk("adclrck", g, 32'(alrck[g]), 32'(bc / 16));
                chk("dacdat", g, 32'(dacdat[g]), 32'(m_word[g][15 - (bc % 16)]));
                chk("sample_req", g, 32'(req[g]), 32'(ph == 0 && bc == 31));
                chk("sample_end", g, 32'(send[g]), 32'(ph == 0 && bc == 16));
                chk("audio_input", g, 32'(ain[g]), 32'(m_in[g]));
                if (req[g] && n_req[g] < 2) begin
                    req_at[g][n_req[g]] = t;
                    n_req[g]++;
                end
            end
        end
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            ao[g]    = 16'($urandom);
            mode[g]  = 2'd2;
            n_req[g] = 0;
        end
        #1;
        check_zero();
        repeat (12) begin
            step();
            for (int g = 0; g < NI; g++) ao[g] = 16'($urandom);
        end

        // directed frame: D=1 loopback, D=2/D=4 against the codec model
        ao[0] = 16'h8001; ao[1] = 16'hA5C3; ao[2] = 16'h0001;
        mode[0] = 2'd1; mode[1] = 2'd0; mode[2] = 2'd0;
        reset_n = 1'b1;
        while (t < 1100) begin
            step();
            if (t == 507) ao[2] = 16'hFFFF;
            if (t == 522) ao[2] = 16'h1234;
        end

        chk("frame_d1_f0", 0, frames[0][0], 32'h00000000);
        chk("frame_d1_f1", 0, frames[0][1], 32'h80018001);
        chk("frame_d2_f1", 1, frames[1][1], 32'hA5C3A5C3);
        chk("frame_d4_f1", 2, frames[2][1], 32'h00010001);
        chk("frame_d4_f2", 2, frames[2][2], 32'hFFFFFFFF);
        chk("frame_d4_f3", 2, frames[2][3], 32'h12341234);
        chk("req_first_d2", 1, 32'(req_at[1][0]), 32'd124);
        chk("req_first_d4", 2, 32'(req_at[2][0]), 32'd248);
        chk("req_period_d1", 0, 32'(req_at[0][1] - req_at[0][0]), 32'd64);
        chk("req_period_d2", 1, 32'(req_at[1][1] - req_at[1][0]), 32'd128);
        chk("req_period_d4", 2, 32'(req_at[2][1] - req_at[2][0]), 32'd256);
        chk("adc_capture_d2", 1, 32'(ain[1]), 32'h1234);
        chk("adc_capture_d4", 2, 32'(ain[2]), 32'h1234);
        chk("loopback_d1", 0, 32'(ain[0]), 32'h8001);

        // asynchronous reset between clk edges, mid-frame
        #2;
        reset_n = 1'b0;
        #1;
        check_zero();
        for (int g = 0; g < NI; g++) mode[g] = 2'd2;
        repeat (6) begin
            step();
            for (int g = 0; g < NI; g++) ao[g] = 16'($urandom);
        end

        // randomized traffic after release
        reset_n = 1'b1;
        mode[0] = 2'd1;
        while (t < 1400) begin
            step();
            for (int g = 0; g < NI; g++)
                if ($urandom_range(0, 7) == 0) ao[g] = 16'($urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/papu_codec_serdes.md
# papu_codec_serdes

Codec-side serializer/deserializer for the PAPU audio path, and the far end of the mixer's `sample_req` / `sample_end` / `audio_output` / `audio_input` handshake. It generates the bit clock and LR clock for an I2S-style left-justified audio codec, and latches each mixer output word. Each word is shifted MSB-first onto both DAC channels. The block also deserializes the codec's left ADC channel back to the mixer.

## Interface
Parameters:
- `BCLK_DIV`, default 16: `clk` cycles per half period of `aud_bclk`. Legal range is ≥1; the default gives ≈48.8 kHz frames at 50 MHz.

Ports:
- `clk`  in  1  system clock. One clock domain; reset is asynchronous and active-low.
- `reset_n`  in  1  asynchronous, active-low reset.
- `audio_output`  in  16  mixer sample, unsigned. Sampled only at the frame start.
- `sample_req`  out  1  one-`clk` pulse requesting that the next mixer word be valid.
- `audio_input`  out  16  last captured left ADC word.
- `sample_end`  out  1  one-`clk` pulse; `audio_input` is updated in the same cycle.
- `aud_bclk`  out  1  codec bit clock.
- `aud_daclrck`  out  1  DAC LR clock (0 = left slot, 1 = right slot).
- `aud_dacdat`  out  1  DAC serial data.
- `aud_adclrck`  out  1  ADC LR clock, always equal to `aud_daclrck`.
- `aud_adcdat`  in  1  ADC serial data. Synchronous to `aud_bclk` and valid around its rising edge.

## Operation
- **Divider:**
  - `div_cnt` counts 0..BCLK_DIV-1. In the cycle where `div_cnt==BCLK_DIV-1` it wraps to 0 and `aud_bclk` toggles.
  - That cycle is a *rise event* if `aud_bclk` was 0, and a *fall event* if it was 1.
- **Frame:**
  - 5-bit `bit_cnt`; one frame is 32 BCLK periods.
  - `bit_cnt` advances only on fall events, wrapping 31→0. Let n denote the new value.
  - Bits 0..15 form the left slot and bits 16..31 the right slot.
- **On each fall event, with new count n:**
  - `aud_daclrck` ← n[4].
  - If n==0: `tx_word` ← `audio_output` and `aud_dacdat` ← `audio_output[15]`. Otherwise `aud_dacdat` ← `tx_word[15-n[3:0]]`.
  - The same word goes out in both slots, MSB first, left-justified (the MSB coincides with the LRCK edge).
  - `sample_req` ← (n==31); otherwise 0.
  - `sample_end` ← (n==16); if n==16, `audio_input` ← `rx_shift`.
- **On each rise event:**
  - If `bit_cnt[4]==0`: `rx_shift` ← {`rx_shift[14:0]`, `aud_adcdat`}.
  - The right ADC slot is ignored.
- **Pulse width:** `sample_req` and `sample_end` are 0 in every cycle that is not the respective fall event, so each is exactly one `clk` wide.
- **Input sampling:** `audio_output` is don't-care except in the n==0 fall-event cycle. Changes at any other time have no effect until the next frame.
- **Reset (asynchronous, any time including mid-frame):**
  - All of the following clear to 0: `div_cnt`, `bit_cnt`, `aud_bclk`, `aud_daclrck`, `aud_dacdat`, `tx_word`, `rx_shift`, `audio_input`, `sample_req`, `sample_end`.
  - After release, the first frame transmits zeros in both slots. The first `sample_req` occurs before the first `audio_output` latch.

## Timing
- BCLK period = 2·BCLK_DIV `clk` cycles; frame = 64·BCLK_DIV `clk` cycles.
- After `reset_n` rises:
  - The first rise event occurs at `clk` edge BCLK_DIV.
  - The first fall event (n=1) occurs at edge 2·BCLK_DIV.
  - The first `sample_req` occurs at edge 62·BCLK_DIV (n=31).
  - The first latch of `audio_output` occurs at edge 64·BCLK_DIV (n=0).
- **Request-to-latch:** `sample_req` to the `audio_output` latch is exactly 2·BCLK_DIV `clk` cycles. The mixer must present a stable word within that window.
- **DAC data timing:** `aud_dacdat` and `aud_daclrck` change only on fall events and are stable across the following rising edge of `aud_bclk`.
- **ADC capture timing:**
  - `audio_input` reflects the 16 left-slot bits sampled on rise events with `bit_cnt` 0..15.
  - It is updated one half-BCLK after the 16th sample, with `sample_end` high in the same cycle.
- **BCLK_DIV=1:** `aud_bclk` toggles every cycle, and every cycle is alternately a rise or a fall event. All of the above must still hold.

## Test plan
- **Reset values:** Hold `reset_n`=0 and drive random `audio_output`/`aud_adcdat`. All outputs must be 0. Assert `reset_n`=0 mid-frame: all outputs must be 0 in the same cycle, without waiting for a `clk` edge.
- **DAC serialization:** BCLK_DIV=2, `audio_output`=16'hA5C3 held.
  - The second frame's left and right slots each shift out 1010 0101 1100 0011, MSB first, on `aud_bclk` rising edges.
  - `aud_daclrck` is 0 for 16 BCLKs, then 1 for 16 BCLKs.
  - The frame period is 128 `clk`.
- **Request cadence:** BCLK_DIV=4.
  - `sample_req` pulses exactly 1 cycle wide, every 256 `clk`.
  - Change `audio_output` from 16'h0001 to 16'hFFFF at 3 cycles after the pulse: the next frame transmits 16'hFFFF.
  - Changing to 16'h1234 at 10 cycles after the latch has no effect until the following frame.
- **ADC capture:** BCLK_DIV=2. A codec model drives 16'h1234 in the left slot and 16'hFFFF in the right slot.
  - `audio_input`=16'h1234 with a 1-cycle `sample_end` at the n==16 fall event.
  - `aud_adclrck` equals `aud_daclrck` throughout.
- **Minimum divider:** BCLK_DIV=1, `audio_output`=16'h8001.
  - `aud_bclk` toggles every cycle and the frame is 64 `clk`.
  - The serialized word is 16'h8001 in both slots.
  - Loopback of `aud_dacdat` to `aud_adcdat` yields `audio_input`=16'h8001.
